// File: rtl/fpu_cmp_pkg.sv
// Shared definitions for the compare-sharing datapath.
// Default sizing plus the default-configuration S1 payload and response shapes.
// Parameterized users declare same-shaped local types at their own widths.
package fpu_cmp_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefIdw   = $clog2(DefNreq);

  typedef struct packed {
    logic [DefWidth-1:0] a;
    logic [DefWidth-1:0] b;
    logic                is_signed;
    logic [DefIdw-1:0]   id;
  } s1_payload_t;

  typedef struct packed {
    logic [DefIdw-1:0] id;
    logic              lt;
  } cmp_resp_t;

endpackage

// File: rtl/slt_cmp_unit.sv
// Combinational set-less-than unit: a + ~b + 1 with carry/overflow selection.
// Ports:
//   a, b      : operands
//   is_signed : 1 = two's-complement compare, 0 = unsigned compare
//   lt        : 1 when a < b under the selected mode
module slt_cmp_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             lt
);

  logic [WIDTH:0] sum;
  logic           carry;
  logic           ovf;

  assign sum   = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
  assign carry = sum[WIDTH];
  // Operands of differing sign whose difference flips away from a's sign overflowed.
  assign ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  // No borrow out means a >= b unsigned; equal operands give carry = 1, sign = 0.
  assign lt    = is_signed ? (sum[WIDTH-1] ^ ovf) : !carry;

endmodule

// File: rtl/slt_share_arb.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared SLT unit.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_signed           : per-requester compare mode
//   resp_valid/ready     : result handshake
//   resp_id, resp_lt     : requester index and less-than result
module slt_share_arb
  import fpu_cmp_pkg::*;
#(
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_signed,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic                  resp_lt
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic [IDW-1:0]   id;
  } s1_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           lt;
  } resp_t;

  logic           s1_v_q;
  s1_t            s1_q;
  s1_t            s1_d;
  logic           out_v_q;
  resp_t          out_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic           gnt_found;
  logic           grant;
  logic           out_adv;
  logic           s1_adv;
  logic           s1_lt;

  assign out_adv = !out_v_q || resp_ready;
  assign s1_adv  = !s1_v_q || out_adv;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // rst_n gate keeps req_ready low for the whole reset window.
  assign grant     = rst_n && s1_adv && gnt_found;
  assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
  assign ptr_d     = grant ? IDW'((32'(gnt_idx) + 1) % NREQ) : ptr_q;

  always_comb begin
    s1_d.a         = req_a[32'(gnt_idx) * WIDTH +: WIDTH];
    s1_d.b         = req_b[32'(gnt_idx) * WIDTH +: WIDTH];
    s1_d.is_signed = req_signed[gnt_idx];
    s1_d.id        = gnt_idx;
  end

  slt_cmp_unit #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a        (s1_q.a),
    .b        (s1_q.b),
    .is_signed(s1_q.is_signed),
    .lt       (s1_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      s1_q    <= '0;
      out_v_q <= 1'b0;
      out_q   <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (out_adv) begin
        out_v_q <= s1_v_q;
        // Payload only moves with a real result so resp_id/resp_lt stay quiet otherwise.
        if (s1_v_q) begin
          out_q.id <= s1_q.id;
          out_q.lt <= s1_lt;
        end
      end
      if (s1_adv) begin
        s1_v_q <= grant;
        if (grant) s1_q <= s1_d;
      end
    end
  end

  assign resp_valid = out_v_q;
  assign resp_id    = out_q.id;
  assign resp_lt    = out_q.lt;

endmodule

// File: tb/tb_slt_share_arb.sv
module tb_slt_share_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_signed;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic                  resp_lt;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: in-order queue of pending results, capacity two.
  typedef struct {
    int id;
    bit lt;
  } item_t;
  item_t m_q[$];
  bit    m_head_out;
  int    m_ptr;

  slt_share_arb #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_signed(req_signed),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_lt   (resp_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = op_a[i];
      req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit ref_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic sgn);
    if (sgn) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_head_out = 1'b0;
    m_ptr      = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    int              g;
    bit              acc;
    logic [NREQ-1:0] exp_rdy;
    item_t           it;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (g < 0 && req_valid[i]) g = i;
    end
    acc     = (g >= 0) && (m_q.size() < 2 || resp_ready);
    exp_rdy = '0;
    if (acc) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("resp_valid", 64'(resp_valid), 64'(m_q.size() > 0 && m_head_out));
    if (m_q.size() > 0 && m_head_out) begin
      check_eq("resp_id", 64'(resp_id), 64'(m_q[0].id));
      check_eq("resp_lt", 64'(resp_lt), 64'(m_q[0].lt));
    end
    if (acc) begin
      it.id = g;
      it.lt = ref_lt(op_a[g], op_b[g], req_signed[g]);
    end
    @(posedge clk);
    if (m_q.size() > 0 && m_head_out && resp_ready) begin
      void'(m_q.pop_front());
      m_head_out = 1'b0;
    end
    if (m_q.size() > 0) m_head_out = 1'b1;
    if (acc) begin
      m_q.push_back(it);
      m_ptr = (g + 1) % NREQ;
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sgn);
    op_a[i]       = a;
    op_b[i]       = b;
    req_signed[i] = sgn;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_signed = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    model_reset();
    req_valid = 4'b1111;
    #1;
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_id", 64'(resp_id), 64'd0);
    check_eq("rst_resp_lt", 64'(resp_lt), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic unsigned compares from requester 0.
    set_req(0, 32'd49, 32'd67, 1'b0); req_valid = 4'b0001; step();
    req_valid = '0; run(2);
    set_req(0, 32'd67, 32'd49, 1'b0); req_valid = 4'b0001; step();
    req_valid = '0; run(2);
    set_req(0, 32'd5, 32'd5, 1'b0);   req_valid = 4'b0001; step();
    req_valid = '0; run(2);

    // Mode check, back to back.
    req_valid = 4'b0001;
    set_req(0, 32'hFFFF_FFFF, 32'd1, 1'b0);          step();
    set_req(0, 32'hFFFF_FFFF, 32'd1, 1'b1);          step();
    set_req(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);  step();
    set_req(0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);  step();
    req_valid = '0; run(2);

    // Round robin across all requesters with distinct operands.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 3), 32'd4, i[0]);
    req_valid = 4'b1111; run(8);

    // Backpressure: output and S1 fill, grants stop, then drain.
    resp_ready = 1'b0; run(5);
    resp_ready = 1'b1; req_valid = '0; run(3);

    // Reset with two results in flight.
    req_valid = 4'b1111; resp_ready = 1'b0; run(3);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("midrst_req_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    run(2);

    // Fairness skip: ptr moved to 2, then only 1 and 3 valid.
    req_valid = 4'b0010; step();
    req_valid = 4'b1010; run(4);
    req_valid = '0; run(2);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_a[i]       = rand_op();
        op_b[i]       = ($urandom_range(0, 7) == 0) ? op_a[i] : rand_op();
        req_signed[i] = 1'($urandom_range(0, 1));
      end
      req_valid  = NREQ'($urandom());
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0; resp_ready = 1'b1; run(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slt_share_arb.md
# slt_share_arb

Round-robin arbiter and two-stage pipeline that shares one WIDTH-bit set-less-than unit among NREQ requesters. The unit computes a + ~b + 1. Each request carries two operands and a signed/unsigned mode bit. Each response returns the 1-bit less-than result tagged with the requester index. The block sits between the FPU's compare-consuming stages (exponent compare, magnitude swap) and the single shared subtract-compare datapath.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand width in bits
- IDW, $clog2(NREQ), width of the requester index

Ports:
- clk  in  1  the block's single clock; rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; the request is accepted when req_valid[i] && req_ready[i] at a clock edge
- req_a  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a
- req_signed  in  NREQ  per-requester mode: 1 = two's-complement compare, 0 = unsigned compare
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts the result
- resp_id  out  IDW  index of the requester that issued the result
- resp_lt  out  1  1 if A < B under the request's mode

## Operation
- Stage S1 register holds: s1_v, a, b, signed, id.
- Output register holds: out_v, id, lt.
- Advance rules:
  - out_adv = !out_v || resp_ready
  - s1_adv = !s1_v || out_adv
- Arbitration (combinational):
  - When s1_adv = 1, grant exactly one valid requester: the first index with req_valid set, searching from ptr upward with wrap.
  - req_ready is one-hot or zero. It is zero whenever s1_adv = 0.
  - req_ready may depend on req_valid. req_valid must not depend on req_ready.
- Round-robin pointer:
  - On an accepted grant to index g, ptr ← (g+1) mod NREQ.
  - With no grant, ptr holds its value.
- Compare (from S1, combinational): {c, s} = a + ~b + 1 at WIDTH+1 bits; ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]).
  - Unsigned: lt = !c.
  - Signed: lt = s[W-1] ^ ovf.
  - a == b gives lt = 0 in both modes.
- On out_adv: out_v ← s1_v, and lt/id are captured from S1. On s1_adv: s1_v ← (grant present), and fields are captured from the granted requester.
- Results are delivered strictly in acceptance order. At most 2 results are in flight.

## Timing
- Reset (asynchronous assert, synchronous deassert at the source): s1_v = 0, out_v = 0, ptr = 0, resp_valid = 0, resp_id = 0, resp_lt = 0, req_ready = all 0 while rst_n is low.
- Latency: a request accepted at edge E0 appears with resp_valid = 1 after edge E1 (2 edges from acceptance).
- Throughput: one accepted request per cycle while resp_ready = 1.
- Backpressure:
  - With resp_ready = 0 and out_v = 1, the output register holds stable: resp_id and resp_lt do not change.
  - S1 fills, then req_ready goes all 0 within that cycle.
- Simultaneous pop and push: when resp_ready = 1 and the pipeline is full, the output and S1 both advance and a new grant is issued in the same cycle. There are no bubbles.
- A requester deasserting req_valid while not granted is legal. An accepted request is never replayed.
- Reset mid-operation: in-flight results are discarded. No resp_valid is asserted until a new request is accepted after reset.
- Single requester continuously valid: granted every cycle. ptr wraps back onto the same index.

## Structure
- Shared package fpu_cmp_pkg holds:
  - localparam defaults for WIDTH and NREQ
  - a typedef for the S1 payload struct {a, b, signed, id}
  - a typedef for the response struct {id, lt}
- One sub-module: slt_cmp_unit (WIDTH). It is purely combinational: inputs a, b, signed; output lt. Internally it does the inverted-B add with carry-in 1 and the carry/overflow selection. It is reusable by other compare users.
- Arbiter priority search and the ptr register stay in slt_share_arb.

## Test plan
- Basic compare: requester 0 sends a = 49, b = 67, unsigned → resp_lt = 1, resp_id = 0 after 2 edges. Then a = 67, b = 49 → 0. Then a = b = 5 → 0.
- Mode check: a = 32'hFFFF_FFFF, b = 1. Unsigned → 0. Signed → 1. Also a = 32'h8000_0000, b = 32'h7FFF_FFFF signed → 1 (overflow path).
- Round-robin: all 4 requesters hold valid for 8 cycles with resp_ready = 1 → grant order 0, 1, 2, 3, 0, 1, 2, 3; one response per cycle, with resp_id in the same order.
- Backpressure: continuous requests; resp_ready = 0 for 5 cycles → exactly 2 results held, req_ready = 0 for the remaining cycles, resp_id/resp_lt stable. On release, results drain in order with none lost or duplicated.
- Fairness skip: only requesters 1 and 3 valid, ptr = 2 → grants 3, 1, 3, 1.
- Reset mid-flight: assert rst_n = 0 with 2 results in flight → resp_valid = 0 and req_ready = 0 immediately. After release, the first grant goes to requester 0 (ptr = 0), with no stale responses.
